// File: rtl/debounce_pkg.sv
// debounce_pkg: state encoding shared by the debounce scheduler
package debounce_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TIMING = 2'd1,
    S_COMMIT = 2'd2
  } state_t;
endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after last
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] j;
  // scan offsets from farthest to nearest so the nearest request after last wins
  always_comb begin
    any = |req;
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last) + k) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces N_IN inputs through one shared stability timer
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int N_MAX       = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_a_p,
  input  logic [N_IN-1:0]         raw_in,
  output logic [N_IN-1:0]         db_out,
  output logic [N_IN-1:0]         rise_pulse,
  output logic [N_IN-1:0]         fall_pulse,
  output logic                    busy,
  output logic [$clog2(N_IN)-1:0] grant_idx
);
  localparam int IW = $clog2(N_IN);
  localparam int CW = $clog2(N_MAX);
  logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q, sync_d;
  logic [N_IN-1:0] sync, pending;
  logic [N_IN-1:0] db_q, db_d, rise_q, rise_d, fall_q, fall_d;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, arb_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic target_q, target_d, busy_q, busy_d, arb_any;

  assign sync       = sync_q[SYNC_STAGES-1];
  assign pending    = sync ^ db_q;
  assign db_out     = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;
  assign grant_idx  = grant_q;

  rr_arbiter #(.N(N_IN)) u_arb (
    .req  (pending),
    .last (last_q),
    .any  (arb_any),
    .idx  (arb_idx)
  );

  // shift raw pins through the synchronizer chain
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};

  // grant the timer, track stability of the owner, commit after N_MAX matches
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    db_d     = db_q;
    rise_d   = '0;
    fall_d   = '0;
    case (state_q)
      S_IDLE: if (arb_any) begin
        grant_d  = arb_idx;
        target_d = sync[arb_idx];
        cnt_d    = '0;
        state_d  = S_TIMING;
      end
      S_TIMING: begin
        if (sync[grant_q] != target_q) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(N_MAX - 1)) state_d = S_COMMIT;
        else cnt_d = cnt_q + CW'(1);
      end
      S_COMMIT: begin
        db_d[grant_q]   = target_q;
        rise_d[grant_q] = target_q;
        fall_d[grant_q] = ~target_q;
        last_d          = grant_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end

  // state registers; reset drops any commit in flight
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      sync_q   <= '0;
      state_q  <= S_IDLE;
      grant_q  <= '0;
      last_q   <= IW'(N_IN - 1);
      target_q <= 1'b0;
      cnt_q    <= '0;
      db_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed scoreboard bench for the shared-timer debouncer
module tb_debounce_scheduler;
  logic clk = 1'b0;
  logic rst_a_p = 1'b1;
  logic [3:0] raw_in = 4'hF;
  logic [3:0] db_out, rise_pulse, fall_pulse;
  logic busy;
  logic [1:0] grant_idx;

  typedef struct {
    int idx;
    bit rise;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int c;

  debounce_scheduler #(.N_IN(4), .N_MAX(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_a_p    (rst_a_p),
    .raw_in     (raw_in),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .grant_idx  (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input bit r, input int at);
    ev_t e;
    e.idx = idx;
    e.rise = r;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rise_pulse[i] || fall_pulse[i]) begin
        ev_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin
          e.idx = -1;
          e.rise = 1'b0;
          e.at = -1;
        end
        chk("pulse_idx", i, e.idx);
        chk("pulse_dir", rise_pulse[i], e.rise);
        chk("pulse_cyc", cyc, e.at);
        chk("db_level", db_out[i], rise_pulse[i]);
      end
    end
    chk("pulse_onehot", $countones({rise_pulse, fall_pulse}) <= 1, 1);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // reset held with all inputs high
    run(3);
    chk("rst_db", db_out, 0);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_fall", fall_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    rst_a_p = 1'b0;
    c = cyc;
    push(0, 1, c + 8);
    push(1, 1, c + 14);
    push(2, 1, c + 20);
    push(3, 1, c + 26);
    run(3);
    chk("t1_busy", busy, 1);
    chk("t1_grant0", grant_idx, 0);
    run(6);
    chk("t1_grant1", grant_idx, 1);
    run(19);
    chk("t1_db", db_out, 4'hF);
    chk("t1_missing", exp_q.size(), 0);
    // single input fall then rise, uncontended
    raw_in = 4'hB;
    push(2, 0, cyc + 8);
    run(10);
    raw_in = 4'hF;
    push(2, 1, cyc + 8);
    run(10);
    chk("t2_db", db_out, 4'hF);
    chk("t2_missing", exp_q.size(), 0);
    // bouncing input: every grant aborts, one rise after the final edge
    raw_in[1] = 1'b0;
    push(1, 0, cyc + 8);
    run(10);
    for (int k = 0; k < 7; k++) begin
      raw_in[1] = ~k[0];
      if (k == 6) push(1, 1, cyc + 8);
      run(3);
    end
    run(8);
    chk("t3_db", db_out, 4'hF);
    chk("t3_missing", exp_q.size(), 0);
    // simultaneous requests after last grant 3: index 0 then 3
    raw_in[0] = 1'b0;
    push(0, 0, cyc + 8);
    run(10);
    raw_in[3] = 1'b0;
    push(3, 0, cyc + 8);
    run(10);
    raw_in = 4'hF;
    push(0, 1, cyc + 8);
    push(3, 1, cyc + 14);
    run(16);
    chk("t4_db", db_out, 4'hF);
    chk("t4_missing", exp_q.size(), 0);
    // fall on index 2 with a short glitch on index 0 while busy
    raw_in[2] = 1'b0;
    push(2, 0, cyc + 8);
    run(4);
    chk("t5_busy", busy, 1);
    chk("t5_grant", grant_idx, 2);
    raw_in[0] = 1'b0;
    run(1);
    raw_in[0] = 1'b1;
    run(8);
    chk("t5_db", db_out, 4'hB);
    chk("t5_missing", exp_q.size(), 0);
    // reset during timing loses the commit; full re-debounce afterwards
    raw_in[2] = 1'b1;
    run(5);
    chk("t6_busy", busy, 1);
    chk("t6_grant", grant_idx, 2);
    rst_a_p = 1'b1;
    #1;
    chk("t6_db", db_out, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_grant_rst", grant_idx, 0);
    chk("t6_pulses", {rise_pulse, fall_pulse}, 0);
    run(2);
    rst_a_p = 1'b0;
    c = cyc;
    push(0, 1, c + 8);
    push(1, 1, c + 14);
    push(2, 1, c + 20);
    push(3, 1, c + 26);
    run(28);
    chk("t6_db_final", db_out, 4'hF);
    chk("t6_missing", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
